// File: rtl/heartbeat_pkg.sv
// ============================================================================
// Module   : heartbeat_pkg
// Purpose  : Shared mode encodings, phase width and BLINK2 pattern for the
//            heartbeat generator. Honours HEARTBEAT_BLINK2_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package heartbeat_pkg;

  typedef enum logic [1:0] {
    HB_TOGGLE = 2'b00,
    HB_PULSE  = 2'b01,
    HB_BLINK2 = 2'b10,
    HB_RSVD   = 2'b11
  } hb_mode_e;

  localparam int HB_PHASE_W = 3;

  // Beat is high when the freshly advanced phase is 1 or 3.
  localparam logic [(1 << HB_PHASE_W)-1:0] HB_BLINK2_MASK = 8'b0000_1010;

  // Folds reserved (and, when compiled out, BLINK2) onto TOGGLE so that
  // mode comparisons reflect actual behaviour.
  function automatic hb_mode_e hb_norm_mode(input logic [1:0] raw);
    hb_mode_e m;
    m = HB_TOGGLE;
    if (raw == 2'b01) m = HB_PULSE;
`ifdef HEARTBEAT_BLINK2_EN
    if (raw == 2'b10) m = HB_BLINK2;
`endif
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/heartbeat_chan.sv
// ============================================================================
// Module   : heartbeat_chan
// Purpose  : One heartbeat channel: programmable divider, shadow/active
//            config and TOGGLE/PULSE/BLINK2 beat (BLINK2 via HEARTBEAT_BLINK2_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module heartbeat_chan
  import heartbeat_pkg::*;
#(
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  output logic             trigger,
  output logic             beat
);

  localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_count, r_div, r_sdiv, w_ndiv;
  hb_mode_e         r_mode, r_smode, w_nmode, w_cfg_mode;
  logic             r_pending, r_trigger, r_beat;
  logic             w_wrap, w_bypass, w_load_shadow, w_apply, w_mode_chg;

  always_comb begin
    w_cfg_mode    = hb_norm_mode(cfg_mode);
    // >= keeps a count left above a newly shrunk div from running away.
    w_wrap        = (r_count >= r_div);
    w_bypass      = enable && !sync_clr && w_wrap && cfg_we;
    w_load_shadow = cfg_we && !w_bypass;
    w_apply       = w_bypass || (r_pending && (sync_clr || !enable || w_wrap));
    w_ndiv        = r_div;
    w_nmode       = r_mode;
    if (w_bypass) begin
      w_ndiv  = cfg_div;
      w_nmode = w_cfg_mode;
    end else if (w_apply) begin
      w_ndiv  = r_sdiv;
      w_nmode = r_smode;
    end
    w_mode_chg = w_apply && (w_nmode != r_mode);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= C_DEFAULT_DIV;
      r_mode    <= HB_TOGGLE;
      r_sdiv    <= C_DEFAULT_DIV;
      r_smode   <= HB_TOGGLE;
      r_pending <= 1'b0;
    end else begin
      r_div     <= w_ndiv;
      r_mode    <= w_nmode;
      r_pending <= w_load_shadow || (r_pending && !w_apply);
      if (w_load_shadow) begin
        r_sdiv  <= cfg_div;
        r_smode <= w_cfg_mode;
      end
    end
  end

`ifdef HEARTBEAT_BLINK2_EN
  logic [HB_PHASE_W-1:0] r_phase, w_phase_nx;
  logic                  w_blink_beat;

  assign w_phase_nx   = r_phase + 1'b1;
  assign w_blink_beat = HB_BLINK2_MASK[w_phase_nx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                           r_phase <= '0;
    else if (sync_clr || w_mode_chg)                        r_phase <= '0;
    else if (enable && w_wrap && (r_mode == HB_BLINK2))     r_phase <= w_phase_nx;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_trigger <= 1'b0;
      r_beat    <= 1'b0;
    end else if (sync_clr) begin
      r_count   <= '0;
      r_trigger <= 1'b0;
      r_beat    <= 1'b0;
    end else if (!enable) begin
      r_trigger <= 1'b0;
      if (w_mode_chg || (r_mode == HB_PULSE)) r_beat <= 1'b0;
    end else if (w_wrap) begin
      r_count   <= '0;
      r_trigger <= 1'b1;
      if (w_mode_chg) begin
        r_beat <= 1'b0;
      end else begin
        case (r_mode)
          HB_PULSE:  r_beat <= 1'b1;
`ifdef HEARTBEAT_BLINK2_EN
          HB_BLINK2: r_beat <= w_blink_beat;
`endif
          default:   r_beat <= ~r_beat;
        endcase
      end
    end else begin
      r_count   <= r_count + 1'b1;
      r_trigger <= 1'b0;
      if (r_mode == HB_PULSE) r_beat <= 1'b0;
    end
  end

  assign trigger = r_trigger;
  assign beat    = r_beat;

endmodule

`default_nettype wire

// File: rtl/heartbeat_multi.sv
// ============================================================================
// Module   : heartbeat_multi
// Purpose  : NUM_CH independent programmable heartbeat/tick channels with
//            shared config port and sync clear. Option: HEARTBEAT_BLINK2_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module heartbeat_multi
  import heartbeat_pkg::*;
#(
  parameter  int          NUM_CH      = 4,
  parameter  int          DIV_W       = 32,
  parameter  int unsigned DEFAULT_DIV = 10000000,
  localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  output logic [NUM_CH-1:0] trigger,
  output logic [NUM_CH-1:0] beat
);

  // Out-of-range cfg_ch values match no channel, so such writes vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic w_we;
    assign w_we = cfg_we && (cfg_ch == CH_W'(i));

    heartbeat_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable[i]),
      .sync_clr (sync_clr),
      .cfg_we   (w_we),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .trigger  (trigger[i]),
      .beat     (beat[i])
    );
  end

endmodule

`default_nettype wire
